// File: rtl/mmul_pkg.sv
// rtl/mmul_pkg.sv - shared state encoding, mode constants and result clamp helper
package mmul_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic MODE_ADD = 1'b0;
    localparam logic MODE_MUL = 1'b1;

    // Width-generic: callers zero-extend into 64 bits and cast the result back to DW.
    function automatic logic [63:0] sat_trunc(input logic [63:0] val, input int dw, input bit sat);
        logic [63:0] max_v;
        max_v = (64'd1 << dw) - 64'd1;
        if (sat && (val > max_v)) begin
            return max_v;
        end
        return val & max_v;
    endfunction

endpackage

// File: rtl/mmul_mac.sv
// rtl/mmul_mac.sv - single multiply-accumulate stage with registered accumulator
module mmul_mac #(
    parameter int DW    = 8,
    parameter int ACC_W = 2*DW+2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clr,
    input  logic             en,
    input  logic             add_only,
    input  logic [DW-1:0]    a,
    input  logic [DW-1:0]    b,
    output logic [ACC_W-1:0] acc_next
);

    logic [ACC_W-1:0] r_acc;
    logic [2*DW-1:0]  w_prod;

    assign w_prod   = a * b;
    assign acc_next = add_only ? (ACC_W'(a) + ACC_W'(b)) : (r_acc + ACC_W'(w_prod));

    // clr wins over en so the final product of a dot product is consumed and dropped in one edge.
    always_ff @(posedge clk) begin
        if (reset || clr) begin
            r_acc <= '0;
        end else if (en) begin
            r_acc <= acc_next;
        end
    end

endmodule

// File: rtl/mmul_seq.sv
// rtl/mmul_seq.sv - sequential NxN matrix multiply / add engine, one MAC per cycle
module mmul_seq
    import mmul_pkg::*;
#(
    parameter int N     = 3,
    parameter int DW    = 8,
    parameter int SAT   = 1,
    parameter int ACC_W = 2*DW+$clog2(N)+1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              enable,
    input  logic              mode,
    input  logic [N*N*DW-1:0] mat_a,
    input  logic [N*N*DW-1:0] mat_b,
    output logic [N*N*DW-1:0] mat_out,
    output logic              busy,
    output logic              done
);

    localparam int IW = (N > 1) ? $clog2(N) : 1;
    localparam int SW = $clog2(N*N*DW+1);
    localparam logic [IW-1:0] LAST = IW'(N-1);

    state_t            r_state, w_state_next;
    logic [N*N*DW-1:0] r_a, r_b, r_scratch, r_mat_out, w_scratch_next;
    logic              r_mode;
    logic [IW-1:0]     r_i, r_j, r_k;

    logic              w_start, w_calc, w_mul;
    logic              w_last_i, w_last_j, w_last_k;
    logic              w_elem_done, w_last_elem;
    int                w_a_idx, w_b_idx, w_o_idx;
    logic [SW-1:0]     w_a_base, w_b_base, w_o_base;
    logic [DW-1:0]     w_a_elem, w_b_elem, w_res;
    logic [ACC_W-1:0]  w_acc_next;

    assign w_start     = (r_state == IDLE) && enable;
    assign w_calc      = (r_state == CALC);
    assign w_mul       = (r_mode == MODE_MUL);
    assign w_last_i    = (r_i == LAST);
    assign w_last_j    = (r_j == LAST);
    assign w_last_k    = (r_k == LAST);
    assign w_elem_done = !w_mul || w_last_k;
    assign w_last_elem = w_calc && w_elem_done && w_last_i && w_last_j;

    // Multiply walks a[i][k]*b[k][j]; add reads a[i][j]+b[i][j].
    always_comb begin
        w_a_idx  = int'(r_i) * N + (w_mul ? int'(r_k) : int'(r_j));
        w_b_idx  = (w_mul ? int'(r_k) : int'(r_i)) * N + int'(r_j);
        w_o_idx  = int'(r_i) * N + int'(r_j);
        w_a_base = SW'(w_a_idx * DW);
        w_b_base = SW'(w_b_idx * DW);
        w_o_base = SW'(w_o_idx * DW);
    end

    assign w_a_elem = r_a[w_a_base +: DW];
    assign w_b_elem = r_b[w_b_base +: DW];

    mmul_mac #(
        .DW    (DW),
        .ACC_W (ACC_W)
    ) u_mac (
        .clk      (clk),
        .reset    (reset),
        .clr      (w_start || (w_calc && w_mul && w_last_k)),
        .en       (w_calc && w_mul),
        .add_only (!w_mul),
        .a        (w_a_elem),
        .b        (w_b_elem),
        .acc_next (w_acc_next)
    );

    assign w_res = DW'(sat_trunc(64'(w_acc_next), DW, SAT != 0));

    // The final element is merged here so mat_out can take it on the same edge.
    always_comb begin
        w_scratch_next = r_scratch;
        if (w_elem_done) begin
            w_scratch_next[w_o_base +: DW] = w_res;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE:    if (enable)      w_state_next = CALC;
            CALC:    if (w_last_elem) w_state_next = DONE;
            DONE:    if (!enable)     w_state_next = IDLE;
            default:                  w_state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_mode    <= MODE_ADD;
            r_i       <= '0;
            r_j       <= '0;
            r_k       <= '0;
            r_scratch <= '0;
            r_mat_out <= '0;
        end else if (w_start) begin
            r_a    <= mat_a;
            r_b    <= mat_b;
            r_mode <= mode;
            r_i    <= '0;
            r_j    <= '0;
            r_k    <= '0;
        end else if (w_calc) begin
            r_scratch <= w_scratch_next;
            if (w_last_elem) begin
                r_mat_out <= w_scratch_next;
            end
            if (!w_elem_done) begin
                r_k <= r_k + 1'b1;
            end else begin
                r_k <= '0;
                if (w_last_j) begin
                    r_j <= '0;
                    r_i <= w_last_i ? '0 : r_i + 1'b1;
                end else begin
                    r_j <= r_j + 1'b1;
                end
            end
        end
    end

    assign mat_out = r_mat_out;
    assign busy    = (r_state == CALC);
    assign done    = (r_state == DONE);

endmodule
